// File: rtl/game_pkg.sv
// Shared types and default constants for the player input controller.
package game_pkg;

    // Per-paddle sequencing states: idle, waiting out the hold delay, auto-repeating.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } mover_state_e;

    // Decoded paddle direction; UP moves toward POS_MIN.
    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_e;

    localparam int DEF_POS_W      = 10;
    localparam int DEF_POS_MIN    = 0;
    localparam int DEF_POS_MAX    = 400;
    localparam int DEF_POS_INIT   = 200;
    localparam int DEF_STEP       = 4;
    localparam int DEF_TICK_DIV   = 833_333;  // 60 Hz repeat at 50 MHz
    localparam int DEF_HOLD_TICKS = 15;

    // Opposing keys cancel; only a single pressed key gives a direction.
    function automatic dir_e decode_dir(input logic up_key, input logic down_key);
        if (up_key && !down_key)
            return DIR_UP;
        if (down_key && !up_key)
            return DIR_DOWN;
        return DIR_NONE;
    endfunction

endpackage

// File: rtl/paddle_mover.sv
// One paddle: key decode, press detection, hold/repeat FSM and saturating position.
module paddle_mover
    import game_pkg::*;
#(
    parameter int POS_W      = DEF_POS_W,
    parameter int POS_MIN    = DEF_POS_MIN,
    parameter int POS_MAX    = DEF_POS_MAX,
    parameter int POS_INIT   = DEF_POS_INIT,
    parameter int STEP       = DEF_STEP,
    parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
    input  logic             clk,
    input  logic             rst,       // async, active low
    input  logic             up_key,
    input  logic             down_key,
    input  logic             tick,
    input  logic             freeze,    // paused now, or a pause edge this cycle
    output logic [POS_W-1:0] pos,
    output logic             move
);

    localparam int PW1 = POS_W + 1;
    localparam int HCW = $clog2(HOLD_TICKS + 1);

    // Arithmetic is done one bit wider so the +STEP / -STEP never wraps.
    localparam logic [PW1-1:0]   MIN_X  = PW1'(POS_MIN);
    localparam logic [PW1-1:0]   MAX_X  = PW1'(POS_MAX);
    localparam logic [PW1-1:0]   STEP_X = PW1'(STEP);
    localparam logic [POS_W-1:0] MIN_P  = POS_W'(POS_MIN);
    localparam logic [POS_W-1:0] MAX_P  = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] INIT_P = POS_W'(POS_INIT);
    localparam logic [HCW-1:0]   HOLD_N = HCW'(HOLD_TICKS);

    logic               up_d, down_d;
    dir_e               dir, prev_dir;
    logic               new_dir;
    mover_state_e       state, state_nxt;
    logic [HCW-1:0]     hold_cnt, hold_nxt;
    logic               step_en;
    logic [PW1-1:0]     pos_x;
    logic [POS_W-1:0]   pos_nxt;

    // The previous direction is the decode of last cycle's key levels, so it
    // keeps tracking the keys even while the FSM is held idle by pause.
    assign dir      = decode_dir(up_key, down_key);
    assign prev_dir = decode_dir(up_d, down_d);
    assign new_dir  = (dir != DIR_NONE) && (dir != prev_dir);
    assign pos_x    = {1'b0, pos};

    // Key edge-detect registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            up_d   <= 1'b0;
            down_d <= 1'b0;
        end else begin
            up_d   <= up_key;
            down_d <= down_key;
        end
    end

    // Next state, hold counter and step request. Pause dominates a press, and
    // a fresh direction (including a reversal) dominates the tick.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        step_en   = 1'b0;
        if (freeze || dir == DIR_NONE) begin
            state_nxt = ST_IDLE;
            hold_nxt  = '0;
        end else if (new_dir) begin
            state_nxt = ST_HOLD;
            hold_nxt  = '0;
            step_en   = 1'b1;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (tick) begin
                        hold_nxt = hold_cnt + 1'b1;
                        if (hold_nxt == HOLD_N)
                            state_nxt = ST_REPEAT;
                    end
                end
                ST_REPEAT: step_en = tick;
                default: ;
            endcase
        end
    end

    // Saturating step toward the decoded direction; clamps instead of wrapping.
    always_comb begin
        pos_nxt = pos;
        if (dir == DIR_UP)
            pos_nxt = (pos_x < MIN_X + STEP_X) ? MIN_P : POS_W'(pos_x - STEP_X);
        else if (dir == DIR_DOWN)
            pos_nxt = (pos_x + STEP_X > MAX_X) ? MAX_P : POS_W'(pos_x + STEP_X);
    end

    // FSM state and hold counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Position register; move pulses only when the value actually changes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos  <= INIT_P;
            move <= 1'b0;
        end else begin
            move <= step_en && (pos_nxt != pos);
            if (step_en)
                pos <= pos_nxt;
        end
    end

endmodule

// File: rtl/game_input_ctrl.sv
// Player input sequencer: repeat-tick prescaler, pause toggle, two paddle movers.
module game_input_ctrl
    import game_pkg::*;
#(
    parameter int POS_W      = DEF_POS_W,
    parameter int POS_MIN    = DEF_POS_MIN,
    parameter int POS_MAX    = DEF_POS_MAX,
    parameter int POS_INIT   = DEF_POS_INIT,
    parameter int STEP       = DEF_STEP,
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
    input  logic             clk,
    input  logic             rst,        // async, active low
    input  logic             w_state,
    input  logic             s_state,
    input  logic             Ua_state,
    input  logic             Da_state,
    input  logic             Pause,
    output logic             paused,
    output logic [POS_W-1:0] left_pos,
    output logic [POS_W-1:0] right_pos,
    output logic             left_move,
    output logic             right_move,
    output logic             tick
);

    localparam int             CW       = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] pre_cnt;
    logic          pause_d;
    logic          pause_rise;
    logic          freeze;

    // Tick is decoded from the count so it is low out of reset (count 0).
    assign tick       = (pre_cnt == CNT_LAST);
    assign pause_rise = Pause & ~pause_d;
    // Freezing on the edge itself makes the pause win over a same-cycle press
    // and drops the FSMs to idle on the same edge that sets paused.
    assign freeze     = paused | pause_rise;

    // Free-running prescaler; keeps counting while paused.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pre_cnt <= '0;
        else if (pre_cnt == CNT_LAST)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + 1'b1;
    end

    // Pause toggles on each rising edge of the key; releases are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pause_d <= 1'b0;
            paused  <= 1'b0;
        end else begin
            pause_d <= Pause;
            if (pause_rise)
                paused <= ~paused;
        end
    end

    paddle_mover #(
        .POS_W(POS_W), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX), .POS_INIT(POS_INIT),
        .STEP(STEP), .HOLD_TICKS(HOLD_TICKS)
    ) u_left (
        .clk(clk), .rst(rst), .up_key(w_state), .down_key(s_state),
        .tick(tick), .freeze(freeze), .pos(left_pos), .move(left_move)
    );

    paddle_mover #(
        .POS_W(POS_W), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX), .POS_INIT(POS_INIT),
        .STEP(STEP), .HOLD_TICKS(HOLD_TICKS)
    ) u_right (
        .clk(clk), .rst(rst), .up_key(Ua_state), .down_key(Da_state),
        .tick(tick), .freeze(freeze), .pos(right_pos), .move(right_move)
    );

endmodule

// File: tb/tb_game_input_ctrl.sv
// Bench for game_input_ctrl: directed vector table, async-reset sequences, random vs model.
module tb_game_input_ctrl;

    localparam int POS_W      = 10;
    localparam int POS_MIN    = 0;
    localparam int POS_MAX    = 20;
    localparam int POS_INIT   = 8;
    localparam int STEP       = 4;
    localparam int TICK_DIV   = 4;
    localparam int HOLD_TICKS = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic w_state = 1'b0, s_state = 1'b0, Ua_state = 1'b0, Da_state = 1'b0, Pause = 1'b0;
    logic paused, left_move, right_move, tick;
    logic [POS_W-1:0] left_pos, right_pos;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    game_input_ctrl #(
        .POS_W(POS_W), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX), .POS_INIT(POS_INIT),
        .STEP(STEP), .TICK_DIV(TICK_DIV), .HOLD_TICKS(HOLD_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .w_state(w_state), .s_state(s_state),
        .Ua_state(Ua_state), .Da_state(Da_state), .Pause(Pause),
        .paused(paused), .left_pos(left_pos), .right_pos(right_pos),
        .left_move(left_move), .right_move(right_move), .tick(tick)
    );

    typedef struct {
        logic w, s, ua, da, p;
        int   lpos, rpos;
        logic lm, rm, pz;
    } vec_t;
    vec_t vecs[$];

    task automatic addn(input int n, input logic w, s, ua, da, p,
                        input int lp, rp, input logic lm, rm, pz);
        vec_t v;
        v.w = w; v.s = s; v.ua = ua; v.da = da; v.p = p;
        v.lpos = lp; v.rpos = rp; v.lm = lm; v.rm = rm; v.pz = pz;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic w, s, ua, da, p);
        w_state = w; s_state = s; Ua_state = ua; Da_state = da; Pause = p;
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic clk_step;
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    // Each paddle tracks: last direction, whether a press chain is live, and
    // how many ticks have elapsed since the press. Steps happen on the press
    // and on every tick after the HOLD_TICKS-th.
    int   m_cnt;
    logic m_paused, m_pause_d;
    int   m_pos[2], m_prev[2], m_ticks[2];
    bit   m_active[2];
    logic m_move[2];

    function automatic int dir_of(input logic u, input logic d);
        if (u && !d) return -1;
        if (d && !u) return 1;
        return 0;
    endfunction

    task automatic model_reset;
        m_cnt = 0; m_paused = 1'b0; m_pause_d = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_pos[i] = POS_INIT; m_prev[i] = 0; m_ticks[i] = 0;
            m_active[i] = 1'b0; m_move[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic w, s, ua, da, p);
        bit t, rise, frz, go;
        int dir[2];
        int np;
        t    = (m_cnt == TICK_DIV - 1);
        rise = p && !m_pause_d;
        frz  = m_paused || rise;
        dir[0] = dir_of(w, s);
        dir[1] = dir_of(ua, da);
        for (int i = 0; i < 2; i++) begin
            go = 1'b0;
            if (frz || dir[i] == 0)
                m_active[i] = 1'b0;
            else if (dir[i] != m_prev[i]) begin
                m_active[i] = 1'b1; m_ticks[i] = 0; go = 1'b1;
            end else if (m_active[i] && t) begin
                m_ticks[i]++;
                go = (m_ticks[i] > HOLD_TICKS);
            end
            m_move[i] = 1'b0;
            if (go) begin
                np = m_pos[i] + dir[i] * STEP;
                if (np < POS_MIN) np = POS_MIN;
                if (np > POS_MAX) np = POS_MAX;
                m_move[i] = (np != m_pos[i]);
                m_pos[i]  = np;
            end
            m_prev[i] = dir[i];
        end
        if (rise) m_paused = !m_paused;
        m_pause_d = p;
        m_cnt = (m_cnt + 1) % TICK_DIV;
    endtask

    initial begin
        logic w, s, ua, da, p;

        // ---- vector table; entry j is applied in cycle 8+j after reset release,
        // ticks fall in cycles where cycle%4 == 3 ----
        //    n  w  s ua da  p  lpos rpos lm rm pz
        // tap up, then tap down back to 8
        addn(1, 1, 0, 0, 0, 0,   4,  8, 1, 0, 0);
        addn(1, 0, 0, 0, 0, 0,   4,  8, 0, 0, 0);
        addn(1, 0, 1, 0, 0, 0,   8,  8, 1, 0, 0);
        addn(1, 0, 0, 0, 0, 0,   8,  8, 0, 0, 0);
        // hold down: step, 2 ticks hold, then step per tick, saturating at 20
        addn(1, 0, 1, 0, 0, 0,  12,  8, 1, 0, 0);
        addn(10,0, 1, 0, 0, 0,  12,  8, 0, 0, 0);
        addn(1, 0, 1, 0, 0, 0,  16,  8, 1, 0, 0);
        addn(3, 0, 1, 0, 0, 0,  16,  8, 0, 0, 0);
        addn(1, 0, 1, 0, 0, 0,  20,  8, 1, 0, 0);
        addn(4, 0, 1, 0, 0, 0,  20,  8, 0, 0, 0);
        addn(1, 0, 0, 0, 0, 0,  20,  8, 0, 0, 0);
        // right: both keys cancel, drop up -> down step, reversal restarts hold
        addn(3, 0, 0, 1, 1, 0,  20,  8, 0, 0, 0);
        addn(1, 0, 0, 0, 1, 0,  20, 12, 0, 1, 0);
        addn(3, 0, 0, 0, 1, 0,  20, 12, 0, 0, 0);
        addn(1, 0, 0, 1, 0, 0,  20,  8, 0, 1, 0);
        addn(10,0, 0, 1, 0, 0,  20,  8, 0, 0, 0);
        addn(1, 0, 0, 1, 0, 0,  20,  4, 0, 1, 0);
        addn(1, 0, 0, 0, 0, 0,  20,  4, 0, 0, 0);
        // pause edge together with a press: pause wins; held key frozen
        addn(1, 1, 0, 0, 0, 1,  20,  4, 0, 0, 1);
        addn(20,1, 0, 0, 0, 0,  20,  4, 0, 0, 1);
        // unpause with key still held: no move until re-pressed
        addn(1, 1, 0, 0, 0, 1,  20,  4, 0, 0, 0);
        addn(10,1, 0, 0, 0, 0,  20,  4, 0, 0, 0);
        addn(1, 0, 0, 0, 0, 0,  20,  4, 0, 0, 0);
        addn(1, 1, 0, 0, 0, 0,  16,  4, 1, 0, 0);
        addn(1, 0, 0, 0, 0, 0,  16,  4, 0, 0, 0);

        // ---- reset ----
        drive(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        check("rst_lpos",   left_pos,   POS_INIT);
        check("rst_rpos",   right_pos,  POS_INIT);
        check("rst_paused", paused,     0);
        check("rst_lmove",  left_move,  0);
        check("rst_rmove",  right_move, 0);
        check("rst_tick",   tick,       0);
        for (int k = 1; k <= 8; k++) begin
            clk_step;
            check($sformatf("tick_c%0d", k), tick, (k % 4 == 3) ? 1 : 0);
        end

        // ---- directed table ----
        foreach (vecs[j]) begin
            drive(vecs[j].w, vecs[j].s, vecs[j].ua, vecs[j].da, vecs[j].p);
            clk_step;
            check($sformatf("v%0d_lpos", j),   left_pos,   vecs[j].lpos);
            check($sformatf("v%0d_rpos", j),   right_pos,  vecs[j].rpos);
            check($sformatf("v%0d_lmove", j),  left_move,  vecs[j].lm);
            check($sformatf("v%0d_rmove", j),  right_move, vecs[j].rm);
            check($sformatf("v%0d_paused", j), paused,     vecs[j].pz);
        end

        // ---- async reset while right paddle is auto-repeating ----
        drive(0, 0, 0, 1, 0);
        repeat (14) clk_step;
        check("pre_arst_rpos_moved", (right_pos != POS_INIT[POS_W-1:0]) ? 1 : 0, 1);
        #1 rst = 1'b0;
        #1;
        check("arst_lpos", left_pos,  POS_INIT);
        check("arst_rpos", right_pos, POS_INIT);
        drive(0, 0, 0, 0, 0);
        clk_step;
        rst = 1'b1;
        // ---- async reset clears paused ----
        drive(0, 0, 0, 0, 1);
        clk_step;
        check("pz_before_arst", paused, 1);
        #1 rst = 1'b0;
        #1;
        check("arst_paused", paused, 0);
        drive(0, 0, 0, 0, 0);
        clk_step;
        rst = 1'b1;

        // ---- random stimulus vs model ----
        model_reset;
        w = 0; s = 0; ua = 0; da = 0; p = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) w  = ~w;
            if ($urandom_range(15) == 0) s  = ~s;
            if ($urandom_range(15) == 0) ua = ~ua;
            if ($urandom_range(15) == 0) da = ~da;
            if ($urandom_range(63) == 0) p  = ~p;
            drive(w, s, ua, da, p);
            model_edge(w, s, ua, da, p);
            clk_step;
            check("rnd_lpos",   left_pos,   m_pos[0]);
            check("rnd_rpos",   right_pos,  m_pos[1]);
            check("rnd_lmove",  left_move,  m_move[0]);
            check("rnd_rmove",  right_move, m_move[1]);
            check("rnd_paused", paused,     m_paused);
            check("rnd_tick",   tick,       (m_cnt == TICK_DIV - 1) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/game_input_ctrl.md
# game_input_ctrl

Sequencing controller between the five debounced player inputs (left up/down, right up/down, pause) and the game engine. It converts debounced key levels into paddle position updates, with an immediate step on press, a hold delay, then timed auto-repeat. It also converts the pause key into a toggled `paused` state that freezes all motion. It sits directly downstream of the debouncer and drives paddle positions into the ball/collision and display logic.

## Interface
- `POS_W`, 10, paddle position width
- `POS_MIN`, 0, top limit
- `POS_MAX`, 400, bottom limit; must be at least `POS_MIN`
- `POS_INIT`, 200, position after reset
- `STEP`, 4, position change per move
- `TICK_DIV`, 833_333, clocks per repeat tick (60 Hz at 50 MHz); must be at least 2
- `HOLD_TICKS`, 15, ticks a key must be held before auto-repeat starts; must be at least 1

- `clk` in 1: system clock
- `rst` in 1: asynchronous, active-low reset
- `w_state` in 1: left paddle up, debounced level
- `s_state` in 1: left paddle down
- `Ua_state` in 1: right paddle up
- `Da_state` in 1: right paddle down
- `Pause` in 1: pause key, debounced level
- `paused` out 1: game frozen when high
- `left_pos` out POS_W: left paddle position
- `right_pos` out POS_W: right paddle position
- `left_move` out 1: one-cycle pulse when `left_pos` changes
- `right_move` out 1: one-cycle pulse when `right_pos` changes
- `tick` out 1: one-cycle repeat-tick pulse, exported for the game engine

## Operation
- All inputs are already synchronous to `clk`. Each input has one `_d` register for edge detection. Its reset value is 0.
- **Prescaler:** free-running counter from 0 to `TICK_DIV-1`.
  - `tick` is high for the one cycle where the count equals `TICK_DIV-1`.
  - The counter keeps running while paused.
- **Pause:** on a rising edge of `Pause` (level 1, `_d` 0), `paused` toggles. Falling edges are ignored.
- **Direction decode, per paddle:**
  - up = upkey & ~downkey
  - down = downkey & ~upkey
  - Both keys high, or neither, means no direction.
- **Per-paddle FSM, states IDLE, HOLD, REPEAT:**
  - IDLE -> HOLD on a new direction (the decoded direction differs from the registered previous direction and is non-zero). One step is issued immediately and the hold counter clears.
  - HOLD: the hold counter increments on each `tick`. On reaching `HOLD_TICKS` the FSM moves to REPEAT. No step is issued on that transition tick.
  - REPEAT: one step is issued per `tick`.
  - HOLD/REPEAT -> IDLE when the direction becomes none.
  - HOLD/REPEAT -> HOLD on a direction reversal (up to down in one cycle). The reversal counts as a new direction: one immediate step and the hold counter clears.
  - While `paused`, the FSM is forced to IDLE, no steps are issued, and the previous-direction register still tracks the keys. A key held through unpause therefore does not move until it is released and pressed again.
- **Step arithmetic:** computed in POS_W+1 bits.
  - Up: pos = max(pos-STEP, POS_MIN).
  - Down: pos = min(pos+STEP, POS_MAX).
  - The `_move` pulse is asserted only if the new value differs from the old one. A saturated step that leaves the position unchanged produces no pulse.
  - A press at a limit does not wrap.
- **Pause and press in the same cycle:** if a pause rising edge and a new direction occur together, the pause edge wins and no step is issued.

## Timing
- **Reset values:** `paused`=0, `left_pos`=`right_pos`=`POS_INIT`, `left_move`=`right_move`=0, `tick`=0, prescaler=0, FSMs in IDLE, hold counters 0.
- **Press latency:** an input first sampled high at edge N updates the position and pulses `_move` on the registers loaded at edge N. Both are visible in the cycle after N, giving 1-cycle latency.
- **Hold timing:** the first repeat step occurs on the tick after HOLD_TICKS ticks have elapsed in HOLD, i.e. on tick number `HOLD_TICKS+1` counted from the press.
- **`paused` latency:** visible 1 cycle after the `Pause` rising edge is sampled.
- **Pause mid-hold:** the FSM returns to IDLE on the edge that registers `paused`=1.
- **Reset mid-operation:** reset takes effect asynchronously. Positions return to `POS_INIT` immediately.

## Structure
- Package `game_pkg` holds:
  - the FSM state enum (IDLE/HOLD/REPEAT)
  - the direction encoding (NONE/UP/DOWN)
  - default constants for the parameters above
- Sub-module `paddle_mover`, instantiated twice, contains:
  - the direction decode
  - the previous-direction register
  - the FSM and hold counter
  - the saturating position register and `_move` pulse
- The top level holds the prescaler, the pause toggle and the two instances.

## Test plan
Parameters for the bench: `TICK_DIV`=4, `HOLD_TICKS`=2, `STEP`=4, `POS_MIN`=0, `POS_MAX`=20, `POS_INIT`=8.

1. **Reset:** release `rst` -> `left_pos`=`right_pos`=8, `paused`=0. `tick` pulses every 4 cycles starting at cycle 3.
2. **Tap:** `w_state` high for 1 cycle -> `left_pos`=4 one cycle later, single `left_move` pulse, no further change.
3. **Hold:** hold `s_state` -> `left_pos` goes 12, then 16 at the 3rd tick, then 20 at the 4th tick. At the 5th tick the position saturates at 20 with no `left_move` pulse.
4. **Conflict and reversal:**
   - `Ua_state` and `Da_state` both high -> `right_pos` stays 8.
   - Drop `Ua_state` -> `right_pos`=12 one cycle later, FSM in HOLD.
   - Swap to `Ua_state` only -> immediate step back to 8, hold counter restarts.
5. **Pause:**
   - Rising edge on `Pause` -> `paused`=1. Hold `w_state` for 20 cycles -> `left_pos` unchanged.
   - Second `Pause` edge -> `paused`=0, still no move while `w_state` is held.
   - Release and re-press `w_state` -> steps.
6. **Async reset in REPEAT:** assert `rst` low mid-cycle -> positions return to 8 and `paused` clears without waiting for a clock edge.
